punc_control_fsm: RTL and testbench
===================================

Name: punc_control_fsm

Overview:
Multi-cycle control unit for the PUnC LC3 processor. It sequences the PUnC datapath through fetch, decode, execute and indirect-execute phases, decoding the instruction register and NZP flags into datapath load, write-enable and mux-select strobes. It sits beside the datapath in the PUnC top level and is the only driver of the datapath control inputs.

Parameters:
NONE_RESERVED, -, none; opcode and select encodings are fixed below.

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
ir  in  16  instruction register contents from datapath
n_flag  in  1  datapath N condition flag
z_flag  in  1  datapath Z condition flag
p_flag  in  1  datapath P condition flag
ir_ld  out  1  load IR from memory read data
pc_inc  out  1  PC <= PC+1
pc_ld  out  1  PC <= pc_data_sel source
pc_data_sel  out  1  0 = address adder, 1 = RF read port 0
adder_base_sel  out  1  address adder base: 0 = PC, 1 = RF read port 0
adder_off_sel  out  2  0 = sext(ir[5:0]), 1 = sext(ir[8:0]), 2 = sext(ir[10:0])
mem_addr_sel  out  2  0 = PC, 1 = address adder, 2 = indirect address register
mem_w_en  out  1  memory write, data = RF read port 1
ind_ld  out  1  indirect address register <= memory read data
rf_r_addr_0  out  3  RF read address 0 (base/SR1)
rf_r_addr_1  out  3  RF read address 1 (SR2/store source)
rf_w_addr  out  3  RF write address
rf_w_en  out  1  RF write enable
rf_w_sel  out  2  0 = PC, 1 = memory data, 2 = ALU result, 3 = address adder
alu_sel  out  2  0 = ADD, 1 = AND, 2 = NOT, 3 = PASS_A
alu_b_sel  out  1  0 = RF read port 1, 1 = sext(ir[4:0])
nzp_ld  out  1  load N/Z/P flags
nzp_sel  out  1  0 = ALU result, 1 = memory data
halted  out  1  high while in HALT
state  out  3  current state, for debug

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, EXEC2=3, HALT=4. Moore outputs from state and ir; every strobe not listed for a state is 0.
- Reset: on any rising edge with rst=1, state <= FETCH. While rst=1, all enables/loads are forced 0 regardless of state. Selects and addresses are don't-care in reset, but are driven to 0.
- FETCH: mem_addr_sel=0, ir_ld=1. Next state is DECODE.
- DECODE: pc_inc=1. Next state is EXEC. Every PC-relative computation in EXEC uses the incremented PC.
- EXEC, by ir[15:12]. Next state is FETCH unless stated otherwise.
  - ADD 0001 / AND 0101: rf_r_addr_0=ir[8:6], rf_r_addr_1=ir[2:0], alu_b_sel=ir[5], alu_sel=0/1, rf_w_en, rf_w_sel=2, rf_w_addr=ir[11:9], nzp_ld, nzp_sel=0.
  - NOT 1001: same, with alu_sel=2.
  - BR 0000: taken = (ir[11]&n)|(ir[10]&z)|(ir[9]&p). If taken, pc_ld, pc_data_sel=0, base PC, off_sel=1. BR with nzp=000 is a NOP.
  - JMP 1100: pc_ld, pc_data_sel=1, rf_r_addr_0=ir[8:6].
  - JSR 0100: rf_w_en, rf_w_addr=7, rf_w_sel=0, pc_ld.
    - ir[11]=1: PC <= adder, base PC, off_sel=2.
    - ir[11]=0: PC <= RF[ir[8:6]].
    - For JSRR R7, the old R7 is the jump target, because the read precedes the same-edge write.
  - LD 0010: mem_addr_sel=1, base PC, off_sel=1, rf write from memory (sel 1) to ir[11:9], nzp_ld, nzp_sel=1.
  - LDR 0110: same as LD, with base RF[ir[8:6]] and off_sel=0.
  - LEA 1110: rf_w_sel=3, base PC, off_sel=1, rf_w_en to ir[11:9]. No flag update.
  - ST 0011 / STR 0111: mem_w_en, rf_r_addr_1=ir[11:9]. Address as for LD / LDR respectively.
  - LDI 1010 / STI 1011: mem_addr_sel=1, base PC, off_sel=1, ind_ld. Next state is EXEC2.
  - TRAP 1111: next state is HALT.
  - 1000 / 1101: NOP.
- EXEC2: mem_addr_sel=2.
  - LDI: rf write mem data to ir[11:9], nzp_ld, nzp_sel=1.
  - STI: mem_w_en, rf_r_addr_1=ir[11:9].
  - Next state is FETCH.
- HALT: halted=1, all strobes 0. Held until rst.
- Latency: 3 cycles per instruction; LDI/STI take 4.
- Memory read is combinational; writes (memory, RF, PC, IR) commit on the edge that ends the state.

Test Plan:
- Reset mid-op: assert rst during EXEC of ST -> mem_w_en=0 that cycle, state=0 next edge, halted=0.
- ADD R1,R2,#-3 (0x12BD) -> states 0,1,2,0; in EXEC alu_b_sel=1, alu_sel=0, rf_w_addr=1, rf_w_en=1, nzp_ld=1.
- BRz +5 (0x0405) with z=1 -> pc_ld=1, adder_off_sel=1. With z=0 and p=1 -> pc_ld=0.
- JSRR R7 (0x41C0) -> rf_w_addr=7, rf_w_sel=0, pc_data_sel=1, rf_r_addr_0=7, all in the same EXEC cycle.
- LDI R3,#2 (0xA602) -> EXEC: ind_ld=1, mem_addr_sel=1. EXEC2: mem_addr_sel=2, rf_w_sel=1, rf_w_addr=3, nzp_sel=1. Total 4 cycles.
- TRAP 0xF025 -> state 4, halted=1 persistent for 20 cycles with all enables 0; rst -> FETCH.

Source files
------------

// File: rtl/punc_control_fsm.sv
// PUnC LC3 multi-cycle control unit.
// Steps the datapath through FETCH -> DECODE -> EXEC (-> EXEC2 for LDI/STI)
// and decodes the IR and NZP flags into datapath strobes. Outputs are Moore:
// a function of the current state register and the IR held by the datapath.
module punc_control_fsm (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir,
  input  logic        n_flag,
  input  logic        z_flag,
  input  logic        p_flag,
  output logic        ir_ld,
  output logic        pc_inc,
  output logic        pc_ld,
  output logic        pc_data_sel,
  output logic        adder_base_sel,
  output logic [1:0]  adder_off_sel,
  output logic [1:0]  mem_addr_sel,
  output logic        mem_w_en,
  output logic        ind_ld,
  output logic [2:0]  rf_r_addr_0,
  output logic [2:0]  rf_r_addr_1,
  output logic [2:0]  rf_w_addr,
  output logic        rf_w_en,
  output logic [1:0]  rf_w_sel,
  output logic [1:0]  alu_sel,
  output logic        alu_b_sel,
  output logic        nzp_ld,
  output logic        nzp_sel,
  output logic        halted,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_EXEC2  = 3'd3,
    S_HALT   = 3'd4
  } state_e;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  // Select encodings driven onto the datapath muxes
  localparam logic [1:0] OFF_6   = 2'd0;
  localparam logic [1:0] OFF_9   = 2'd1;
  localparam logic [1:0] OFF_11  = 2'd2;
  localparam logic [1:0] MA_PC   = 2'd0;
  localparam logic [1:0] MA_ADD  = 2'd1;
  localparam logic [1:0] MA_IND  = 2'd2;
  localparam logic [1:0] WS_PC   = 2'd0;
  localparam logic [1:0] WS_MEM  = 2'd1;
  localparam logic [1:0] WS_ALU  = 2'd2;
  localparam logic [1:0] WS_ADD  = 2'd3;
  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_AND = 2'd1;
  localparam logic [1:0] ALU_NOT = 2'd2;

  state_e state_q, state_d;

  logic [3:0] opc;
  logic [2:0] dr, sr1, sr2;
  logic       br_taken;
  logic       unused_ir;

  assign opc       = ir[15:12];
  assign dr        = ir[11:9];
  assign sr1       = ir[8:6];
  assign sr2       = ir[2:0];
  assign br_taken  = (ir[11] & n_flag) | (ir[10] & z_flag) | (ir[9] & p_flag);
  // ir[4:3] are fixed zero bits of the register-mode ALU format
  assign unused_ir = ^ir[4:3];

  assign state  = state_q;
  assign halted = (state_q == S_HALT);

  // Next-state sequencing; only LDI/STI take the extra indirect cycle
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (opc == OP_LDI || opc == OP_STI) state_d = S_EXEC2;
        else if (opc == OP_TRAP)            state_d = S_HALT;
        else                                state_d = S_FETCH;
      end
      S_EXEC2:  state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  // State register with synchronous reset back to FETCH
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Strobe decode; everything defaults to 0 and stays 0 while rst is high
  always_comb begin
    ir_ld          = 1'b0;
    pc_inc         = 1'b0;
    pc_ld          = 1'b0;
    pc_data_sel    = 1'b0;
    adder_base_sel = 1'b0;
    adder_off_sel  = OFF_6;
    mem_addr_sel   = MA_PC;
    mem_w_en       = 1'b0;
    ind_ld         = 1'b0;
    rf_r_addr_0    = 3'd0;
    rf_r_addr_1    = 3'd0;
    rf_w_addr      = 3'd0;
    rf_w_en        = 1'b0;
    rf_w_sel       = WS_PC;
    alu_sel        = ALU_ADD;
    alu_b_sel      = 1'b0;
    nzp_ld         = 1'b0;
    nzp_sel        = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_addr_sel = MA_PC;
          ir_ld        = 1'b1;
        end
        S_DECODE: pc_inc = 1'b1;
        S_EXEC: begin
          case (opc)
            OP_ADD, OP_AND, OP_NOT: begin
              rf_r_addr_0 = sr1;
              rf_r_addr_1 = sr2;
              alu_b_sel   = ir[5];
              alu_sel     = (opc == OP_ADD) ? ALU_ADD :
                            (opc == OP_AND) ? ALU_AND : ALU_NOT;
              rf_w_en     = 1'b1;
              rf_w_sel    = WS_ALU;
              rf_w_addr   = dr;
              nzp_ld      = 1'b1;
              nzp_sel     = 1'b0;
            end
            OP_BR: begin
              // nzp=000 never matches, so it falls out as a NOP
              if (br_taken) begin
                pc_ld          = 1'b1;
                pc_data_sel    = 1'b0;
                adder_base_sel = 1'b0;
                adder_off_sel  = OFF_9;
              end
            end
            OP_JMP: begin
              pc_ld       = 1'b1;
              pc_data_sel = 1'b1;
              rf_r_addr_0 = sr1;
            end
            OP_JSR: begin
              // RF read of the base precedes the R7 write on the same edge,
              // so JSRR R7 jumps to the old R7
              rf_w_en   = 1'b1;
              rf_w_addr = 3'd7;
              rf_w_sel  = WS_PC;
              pc_ld     = 1'b1;
              if (ir[11]) begin
                pc_data_sel    = 1'b0;
                adder_base_sel = 1'b0;
                adder_off_sel  = OFF_11;
              end else begin
                pc_data_sel = 1'b1;
                rf_r_addr_0 = sr1;
              end
            end
            OP_LD, OP_LDR: begin
              mem_addr_sel = MA_ADD;
              if (opc == OP_LDR) begin
                adder_base_sel = 1'b1;
                adder_off_sel  = OFF_6;
                rf_r_addr_0    = sr1;
              end else begin
                adder_base_sel = 1'b0;
                adder_off_sel  = OFF_9;
              end
              rf_w_en   = 1'b1;
              rf_w_sel  = WS_MEM;
              rf_w_addr = dr;
              nzp_ld    = 1'b1;
              nzp_sel   = 1'b1;
            end
            OP_LEA: begin
              adder_base_sel = 1'b0;
              adder_off_sel  = OFF_9;
              rf_w_en        = 1'b1;
              rf_w_sel       = WS_ADD;
              rf_w_addr      = dr;
            end
            OP_ST, OP_STR: begin
              mem_addr_sel = MA_ADD;
              if (opc == OP_STR) begin
                adder_base_sel = 1'b1;
                adder_off_sel  = OFF_6;
                rf_r_addr_0    = sr1;
              end else begin
                adder_base_sel = 1'b0;
                adder_off_sel  = OFF_9;
              end
              mem_w_en    = 1'b1;
              rf_r_addr_1 = dr;
            end
            OP_LDI, OP_STI: begin
              // First hop: fetch the pointer into the indirect register
              mem_addr_sel   = MA_ADD;
              adder_base_sel = 1'b0;
              adder_off_sel  = OFF_9;
              ind_ld         = 1'b1;
            end
            default: ;  // TRAP and reserved opcodes drive nothing
          endcase
        end
        S_EXEC2: begin
          // Second hop: access memory through the indirect register
          mem_addr_sel = MA_IND;
          if (opc == OP_LDI) begin
            rf_w_en   = 1'b1;
            rf_w_sel  = WS_MEM;
            rf_w_addr = dr;
            nzp_ld    = 1'b1;
            nzp_sel   = 1'b1;
          end else if (opc == OP_STI) begin
            mem_w_en    = 1'b1;
            rf_r_addr_1 = dr;
          end
        end
        default: ;  // HALT: all strobes stay 0
      endcase
    end
  end

endmodule

// File: tb/tb_punc_control_fsm.sv
// Directed-vector bench for punc_control_fsm with hand-computed expectations.
module tb_punc_control_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ir;
  logic        n_flag, z_flag, p_flag;
  logic        ir_ld, pc_inc, pc_ld, pc_data_sel, adder_base_sel;
  logic [1:0]  adder_off_sel, mem_addr_sel;
  logic        mem_w_en, ind_ld;
  logic [2:0]  rf_r_addr_0, rf_r_addr_1, rf_w_addr;
  logic        rf_w_en;
  logic [1:0]  rf_w_sel, alu_sel;
  logic        alu_b_sel, nzp_ld, nzp_sel, halted;
  logic [2:0]  state;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  punc_control_fsm dut (
    .clk(clk), .rst(rst), .ir(ir),
    .n_flag(n_flag), .z_flag(z_flag), .p_flag(p_flag),
    .ir_ld(ir_ld), .pc_inc(pc_inc), .pc_ld(pc_ld), .pc_data_sel(pc_data_sel),
    .adder_base_sel(adder_base_sel), .adder_off_sel(adder_off_sel),
    .mem_addr_sel(mem_addr_sel), .mem_w_en(mem_w_en), .ind_ld(ind_ld),
    .rf_r_addr_0(rf_r_addr_0), .rf_r_addr_1(rf_r_addr_1), .rf_w_addr(rf_w_addr),
    .rf_w_en(rf_w_en), .rf_w_sel(rf_w_sel), .alu_sel(alu_sel),
    .alu_b_sel(alu_b_sel), .nzp_ld(nzp_ld), .nzp_sel(nzp_sel),
    .halted(halted), .state(state)
  );

  wire [6:0] enables = {ir_ld, pc_inc, pc_ld, mem_w_en, ind_ld, rf_w_en, nzp_ld};

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // From FETCH, load an instruction and walk through DECODE into EXEC
  task automatic to_exec(input logic [15:0] instr);
    ir = instr;
    chk("fetch.state", 16'(state), 16'd0);
    chk("fetch.ir_ld", 16'(ir_ld), 16'd1);
    chk("fetch.mem_addr_sel", 16'(mem_addr_sel), 16'd0);
    step();
    chk("decode.state", 16'(state), 16'd1);
    chk("decode.enables", 16'(enables), 16'b0100000);
    step();
    chk("exec.state", 16'(state), 16'd2);
  endtask

  initial begin
    rst = 1'b1; ir = 16'h0000; n_flag = 0; z_flag = 0; p_flag = 0;
    #1;
    step(); step();
    chk("rst.state", 16'(state), 16'd0);
    chk("rst.enables", 16'(enables), 16'd0);
    chk("rst.halted", 16'(halted), 16'd0);
    rst = 1'b0;
    #1;

    // ADD R1,R2,#-3
    to_exec(16'h12BD);
    chk("add.alu_b_sel", 16'(alu_b_sel), 16'd1);
    chk("add.alu_sel", 16'(alu_sel), 16'd0);
    chk("add.rf_w_addr", 16'(rf_w_addr), 16'd1);
    chk("add.rf_r_addr_0", 16'(rf_r_addr_0), 16'd2);
    chk("add.rf_w_sel", 16'(rf_w_sel), 16'd2);
    chk("add.enables", 16'(enables), 16'b0000011);
    step();
    chk("add.back_to_fetch", 16'(state), 16'd0);

    // AND R3,R4,R5 (register mode)
    to_exec(16'h5705);
    chk("and.alu_sel", 16'(alu_sel), 16'd1);
    chk("and.alu_b_sel", 16'(alu_b_sel), 16'd0);
    chk("and.rf_r_addr_1", 16'(rf_r_addr_1), 16'd5);
    step();

    // BRz +5, taken with z=1
    z_flag = 1;
    to_exec(16'h0405);
    chk("brz_t.pc_ld", 16'(pc_ld), 16'd1);
    chk("brz_t.off_sel", 16'(adder_off_sel), 16'd1);
    chk("brz_t.pc_data_sel", 16'(pc_data_sel), 16'd0);
    chk("brz_t.base_sel", 16'(adder_base_sel), 16'd0);
    step();
    // BRz +5, not taken with z=0,p=1
    z_flag = 0; p_flag = 1;
    to_exec(16'h0405);
    chk("brz_nt.pc_ld", 16'(pc_ld), 16'd0);
    step();
    // BR with nzp=000 is a NOP even with all flags set
    n_flag = 1; z_flag = 1; p_flag = 1;
    to_exec(16'h0005);
    chk("br000.enables", 16'(enables), 16'd0);
    step();
    n_flag = 0; z_flag = 0; p_flag = 0;

    // JSRR R7
    to_exec(16'h41C0);
    chk("jsrr.rf_w_addr", 16'(rf_w_addr), 16'd7);
    chk("jsrr.rf_w_sel", 16'(rf_w_sel), 16'd0);
    chk("jsrr.pc_data_sel", 16'(pc_data_sel), 16'd1);
    chk("jsrr.rf_r_addr_0", 16'(rf_r_addr_0), 16'd7);
    chk("jsrr.enables", 16'(enables), 16'b0010010);
    step();
    // JSR +5 (PC-relative)
    to_exec(16'h4805);
    chk("jsr.pc_data_sel", 16'(pc_data_sel), 16'd0);
    chk("jsr.off_sel", 16'(adder_off_sel), 16'd2);
    chk("jsr.pc_ld", 16'(pc_ld), 16'd1);
    step();

    // LDR R5,R1,#3
    to_exec(16'h6A43);
    chk("ldr.base_sel", 16'(adder_base_sel), 16'd1);
    chk("ldr.off_sel", 16'(adder_off_sel), 16'd0);
    chk("ldr.mem_addr_sel", 16'(mem_addr_sel), 16'd1);
    chk("ldr.rf_w_addr", 16'(rf_w_addr), 16'd5);
    chk("ldr.nzp_sel", 16'(nzp_sel), 16'd1);
    step();

    // LEA R2,#4: write adder result, no flag update
    to_exec(16'hE404);
    chk("lea.rf_w_sel", 16'(rf_w_sel), 16'd3);
    chk("lea.enables", 16'(enables), 16'b0000010);
    step();

    // LDI R3,#2
    to_exec(16'hA602);
    chk("ldi.ind_ld", 16'(ind_ld), 16'd1);
    chk("ldi.mem_addr_sel1", 16'(mem_addr_sel), 16'd1);
    chk("ldi.rf_w_en1", 16'(rf_w_en), 16'd0);
    step();
    chk("ldi.state2", 16'(state), 16'd3);
    chk("ldi.mem_addr_sel2", 16'(mem_addr_sel), 16'd2);
    chk("ldi.rf_w_sel", 16'(rf_w_sel), 16'd1);
    chk("ldi.rf_w_addr", 16'(rf_w_addr), 16'd3);
    chk("ldi.nzp_sel", 16'(nzp_sel), 16'd1);
    chk("ldi.enables2", 16'(enables), 16'b0000011);
    step();
    chk("ldi.back_to_fetch", 16'(state), 16'd0);

    // STI R3,#2
    to_exec(16'hB602);
    step();
    chk("sti.state2", 16'(state), 16'd3);
    chk("sti.enables2", 16'(enables), 16'b0001000);
    chk("sti.rf_r_addr_1", 16'(rf_r_addr_1), 16'd3);
    step();

    // ST R3,#5 with reset asserted mid-EXEC
    to_exec(16'h3605);
    chk("st.mem_w_en", 16'(mem_w_en), 16'd1);
    chk("st.rf_r_addr_1", 16'(rf_r_addr_1), 16'd3);
    rst = 1'b1;
    #1;
    chk("st_rst.mem_w_en", 16'(mem_w_en), 16'd0);
    chk("st_rst.enables", 16'(enables), 16'd0);
    step();
    chk("st_rst.state", 16'(state), 16'd0);
    chk("st_rst.halted", 16'(halted), 16'd0);
    rst = 1'b0;
    #1;

    // TRAP: halt and stay halted until reset
    to_exec(16'hF025);
    chk("trap.enables", 16'(enables), 16'd0);
    step();
    for (int i = 0; i < 20; i++) begin
      chk("halt.state", 16'(state), 16'd4);
      chk("halt.halted", 16'(halted), 16'd1);
      chk("halt.enables", 16'(enables), 16'd0);
      step();
    end
    rst = 1'b1;
    step();
    chk("halt_rst.state", 16'(state), 16'd0);
    chk("halt_rst.halted", 16'(halted), 16'd0);
    rst = 1'b0;
    #1;
    chk("post_rst.ir_ld", 16'(ir_ld), 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
